// File: rtl/reg_file.sv
// MIPS architectural register file: 2^ADDR_WIDTH x DATA_WIDTH, two combinational
// read ports, one clocked write port, r0 hardwired to zero.
// Optional macro REGFILE_BYPASS_EN forwards the in-flight write data to matching read ports.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  // Flattened view of the array; entry 0 is a constant, never a flop.
  logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == 0) begin : g_zero
      assign w_regs[i] = '0;
    end else begin : g_store
      logic                  w_wr_en;
      logic [DATA_WIDTH-1:0] r_q;

      assign w_wr_en = RegWrite && (WriteReg == ADDR_WIDTH'(i));

      // NOTE: every register sits on the async reset because reset must clear the
      // whole architectural state at once; this rules out mapping onto a RAM macro.
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          r_q <= '0;
        end else if (w_wr_en) begin
          r_q <= WriteData;
        end
      end

      assign w_regs[i] = r_q;
    end
  end

  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

  // NOTE: defaults are assigned first so every path through the block drives both
  // outputs and no latch is inferred when the forwarding branch is not taken.
  always_comb begin
    w_rd1 = w_regs[ReadReg1];
    w_rd2 = w_regs[ReadReg2];
`ifdef REGFILE_BYPASS_EN
    if (Rst_n && RegWrite && (WriteReg != '0)) begin
      if (ReadReg1 == WriteReg) w_rd1 = WriteData;
      if (ReadReg2 == WriteReg) w_rd2 = WriteData;
    end
`endif
  end

  assign ReadData1 = w_rd1;
  assign ReadData2 = w_rd2;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: reference array model plus an expected-value queue.
// Build with +define+REGFILE_BYPASS_EN to check the forwarding variant.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 1 << AW;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          RegWrite;
  logic [AW-1:0] WriteReg;
  logic [DW-1:0] WriteData;
  logic [AW-1:0] ReadReg1;
  logic [AW-1:0] ReadReg2;
  logic [DW-1:0] ReadData1;
  logic [DW-1:0] ReadData2;

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .RegWrite (RegWrite),
    .WriteReg (WriteReg),
    .WriteData(WriteData),
    .ReadReg1 (ReadReg1),
    .ReadReg2 (ReadReg2),
    .ReadData1(ReadData1),
    .ReadData2(ReadData2)
  );

  always #5 Clk = ~Clk;

  logic [DW-1:0] model [NR];
  logic [DW-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (Rst_n && RegWrite && WriteReg == a) return WriteData;
`endif
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  task automatic set_write(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    RegWrite  = en;
    WriteReg  = a;
    WriteData = d;
  endtask

  // One rising edge: the model captures exactly what the register file should.
  task automatic tick();
    @(posedge Clk);
    if (Rst_n && RegWrite && WriteReg != '0) model[WriteReg] = WriteData;
    @(negedge Clk);
    RegWrite = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_write(1'b1, a, d);
    tick();
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    ReadReg1 = a1;
    ReadReg2 = a2;
    exp_q.push_back(exp_read(a1));
    exp_q.push_back(exp_read(a2));
    #1;
    check({tag, "_p1"}, ReadData1, exp_q.pop_front());
    check({tag, "_p2"}, ReadData2, exp_q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst_n = 1'b0;
    set_write(1'b0, '0, '0);
    ReadReg1 = '0;
    ReadReg2 = '0;
    clear_model();

    // Reset state, with a write presented while reset is held.
    @(negedge Clk);
    read_check("rst_state", 5'd5, 5'd31);
    set_write(1'b1, 5'd4, 32'h5555_AAAA);
    read_check("rst_fwd_suppr", 5'd4, 5'd4);
    tick();
    read_check("rst_wr_ignored", 5'd4, 5'd0);
    Rst_n = 1'b1;

    // First edge after release accepts a write.
    do_write(5'd8, 32'h1234_5678);
    do_write(5'd31, 32'hCAFE_F00D);
    read_check("basic", 5'd8, 5'd31);
    read_check("same_idx", 5'd8, 5'd8);

    // Register 0 protection, during and after the write cycle.
    set_write(1'b1, 5'd0, 32'hFFFF_FFFF);
    read_check("r0_pre", 5'd0, 5'd0);
    tick();
    read_check("r0_post", 5'd0, 5'd8);

    // Write disabled.
    do_write(5'd9, 32'h0000_0011);
    set_write(1'b0, 5'd9, 32'hAAAA_AAAA);
    read_check("wr_dis_pre", 5'd9, 5'd9);
    tick();
    read_check("wr_dis_post", 5'd9, 5'd9);

    // Same-cycle hazard: old value (or forwarded value) before the edge, new after.
    do_write(5'd3, 32'h1);
    set_write(1'b1, 5'd3, 32'h2);
    read_check("hazard_pre", 5'd3, 5'd3);
    tick();
    read_check("hazard_post", 5'd3, 5'd3);

    // Forwarding is per port: only port 2 matches the write index.
    set_write(1'b1, 5'd31, 32'h0BAD_CAFE);
    read_check("per_port", 5'd8, 5'd31);
    tick();

    // Back-to-back writes to one index: each value visible for a cycle.
    do_write(5'd10, 32'h0000_000A);
    read_check("b2b_first", 5'd10, 5'd9);
    do_write(5'd10, 32'h0000_000B);
    read_check("b2b_last", 5'd10, 5'd10);

    // Mid-cycle reset with a write pending: clears at once, pending write lost.
    do_write(5'd5, 32'hDEAD_BEEF);
    read_check("pre_rst", 5'd5, 5'd8);
    set_write(1'b1, 5'd6, 32'h6666_6666);
    #2;
    Rst_n = 1'b0;
    clear_model();
    read_check("async_rst", 5'd5, 5'd6);
    tick();
    read_check("rst_pending_lost", 5'd6, 5'd31);
    Rst_n = 1'b1;

    // Sweep every register, port 2 walking in the opposite direction.
    for (int i = 1; i < NR; i++) do_write(AW'(i), DW'(i) * 32'h0101_0101);
    for (int i = 0; i < NR; i++) read_check($sformatf("sweep_%0d", i), AW'(i), AW'(NR - 1 - i));

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
